// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register file / scoreboard slice.
//   - default geometry (data width, register count, counter width)
//   - register address typedef for the default geometry
//   - cnt_max(): the saturation value of a pending-writer counter
package rf_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_NREGS  = 4;
    localparam int RF_CNT_W  = 2;
    localparam int RF_ADDR_W = $clog2(RF_NREGS);

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    // Largest number of in-flight writers a counter of cnt_w bits can track.
    function automatic int unsigned cnt_max(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/rf_pending_cnt.sv
// rf_pending_cnt: one saturating up/down pending-writer counter.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   synchronous active-low reset, clears cnt
//   inc      in   one more producer issued
//   dec      in   one producer wrote back
//   cnt      out  current count
//   is_zero  out  cnt == 0
//   is_one   out  cnt == 1
//   is_max   out  cnt == 2^CNT_W-1
//
// inc is ignored at max and dec is ignored at zero, so the counter never
// wraps in either direction. inc and dec together cancel.
module rf_pending_cnt
    import rf_pkg::*;
#(
    parameter int CNT_W = RF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             is_zero,
    output logic             is_one,
    output logic             is_max
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic inc_ok;
    logic dec_ok;

    assign is_zero = (cnt == '0);
    assign is_one  = (cnt == CNT_W'(1));
    assign is_max  = (cnt == CNT_MAX);

    assign inc_ok = inc && !is_max;
    assign dec_ok = dec && !is_zero;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (inc_ok && !dec_ok) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: register file with write-to-read forwarding and a
// per-register pending-writer scoreboard.
//
// Ports:
//   clk, reset_n            clock and synchronous active-low reset
//   rd_addr1/2              read addresses
//   rd_data1/2              combinational read data (forwarded from wr_data)
//   rd_ready1/2             register has no outstanding producer (or its
//                           last producer retires this cycle)
//   wr_en/wr_addr/wr_data   writeback port; also retires one producer
//   issue_en/issue_addr     decode issues a producer for issue_addr
//   issue_full              issue_addr already tracks the maximum producers
//
// With ZERO_REG=1, register 0 reads 0, ignores writes and issues and is
// always ready.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NREGS    = RF_NREGS,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int CNT_W    = RF_CNT_W,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_ready1,
    output logic              rd_ready2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_full
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [NREGS];

    logic [CNT_W-1:0]  cnt_arr [NREGS];
    logic [NREGS-1:0]  is_zero;
    logic [NREGS-1:0]  is_one;
    logic [NREGS-1:0]  is_max;

    logic wr_to_zero;
    assign wr_to_zero = ZR && (wr_addr == '0);

    // ------------------------------------------------------------------
    // Data storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && !wr_to_zero) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Pending-writer counters
    // ------------------------------------------------------------------
    for (genvar r = 0; r < NREGS; r++) begin : g_cnt
        logic inc_r;
        logic dec_r;
        logic tracked;

        // Register 0 is hard-wired in the zero-register variant and never
        // becomes pending.
        assign tracked = !(ZR && (r == 0));
        assign inc_r   = tracked && issue_en && (issue_addr == ADDR_W'(r)) && !is_max[r];
        assign dec_r   = tracked && wr_en && (wr_addr == ADDR_W'(r)) && !is_zero[r];

        rf_pending_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (inc_r),
            .dec     (dec_r),
            .cnt     (cnt_arr[r]),
            .is_zero (is_zero[r]),
            .is_one  (is_one[r]),
            .is_max  (is_max[r])
        );
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic fwd1;
    logic fwd2;

    assign fwd1 = wr_en && (wr_addr == rd_addr1);
    assign fwd2 = wr_en && (wr_addr == rd_addr2);

    always_comb begin
        rd_data1 = fwd1 ? wr_data : mem[rd_addr1];
        if (ZR && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end
    end

    always_comb begin
        rd_data2 = fwd2 ? wr_data : mem[rd_addr2];
        if (ZR && (rd_addr2 == '0)) begin
            rd_data2 = '0;
        end
    end

    // A register whose single remaining producer writes back this cycle is
    // already usable: its value is on the forwarding path. A same-cycle
    // issue only shows up once the counter has moved.
    always_comb begin
        rd_ready1 = (cnt_arr[rd_addr1] == '0) || (is_one[rd_addr1] && fwd1);
        if (ZR && (rd_addr1 == '0)) begin
            rd_ready1 = 1'b1;
        end
    end

    always_comb begin
        rd_ready2 = (cnt_arr[rd_addr2] == '0) || (is_one[rd_addr2] && fwd2);
        if (ZR && (rd_addr2 == '0)) begin
            rd_ready2 = 1'b1;
        end
    end

    // Pessimistic: a writeback in the same cycle does not free a slot early.
    assign issue_full = is_max[issue_addr];

endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;
    import rf_pkg::*;

    logic           clk;
    logic           reset_n;
    rf_addr_t       rd_addr1, rd_addr2, wr_addr, issue_addr;
    logic           wr_en, issue_en;
    logic [15:0]    wr_data;

    logic [15:0]    rd_data1, rd_data2;
    logic           rd_ready1, rd_ready2, issue_full;
    logic [15:0]    z_rd_data1, z_rd_data2;
    logic           z_rd_ready1, z_rd_ready2, z_issue_full;

    int checks = 0;
    int errors = 0;

    rf_scoreboard #(.ZERO_REG(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_ready1(rd_ready1), .rd_ready2(rd_ready2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .issue_full(issue_full)
    );

    rf_scoreboard #(.ZERO_REG(1)) dut_z (
        .clk(clk), .reset_n(reset_n),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(z_rd_data1), .rd_data2(z_rd_data2),
        .rd_ready1(z_rd_ready1), .rd_ready2(z_rd_ready2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .issue_full(z_issue_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        we;
        rf_addr_t    wa;
        logic [15:0] wd;
        logic        ie;
        rf_addr_t    ia;
        rf_addr_t    ra1;
        rf_addr_t    ra2;
        logic        chk;
        logic [15:0] ed1;
        logic [15:0] ed2;
        logic        er1;
        logic        er2;
        logic        ef;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic we, rf_addr_t wa, logic [15:0] wd,
                                logic ie, rf_addr_t ia, rf_addr_t ra1, rf_addr_t ra2,
                                logic chk, logic [15:0] ed1, logic [15:0] ed2,
                                logic er1, logic er2, logic ef);
        vec_t v;
        v.rst_n = rst_n; v.we = we; v.wa = wa; v.wd = wd;
        v.ie = ie; v.ia = ia; v.ra1 = ra1; v.ra2 = ra2;
        v.chk = chk; v.ed1 = ed1; v.ed2 = ed2;
        v.er1 = er1; v.er2 = er2; v.ef = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst_n, input logic we, input rf_addr_t wa,
                         input logic [15:0] wd, input logic ie, input rf_addr_t ia,
                         input rf_addr_t ra1, input rf_addr_t ra2);
        reset_n = rst_n; wr_en = we; wr_addr = wa; wr_data = wd;
        issue_en = ie; issue_addr = ia; rd_addr1 = ra1; rd_addr2 = ra2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd0, 2'd0);

        //           rst we wa  wd        ie ia  ra1 ra2 chk ed1       ed2       r1 r2 full
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 3, 1, 16'h0000, 16'h0000, 1, 1, 0));
        vecs.push_back(mk(1, 1, 2, 16'hABCD, 0, 0, 2, 1, 1, 16'hABCD, 16'h0000, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 2, 2, 1, 16'hABCD, 16'hABCD, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 2, 1, 16'h0000, 16'hABCD, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 2, 1, 16'h0000, 16'hABCD, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 16'h0011, 0, 1, 1, 1, 1, 16'h0011, 16'h0011, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 16'h0022, 0, 1, 1, 2, 1, 16'h0022, 16'hABCD, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 1, 3, 1, 16'h0022, 16'h0000, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 3, 3, 0, 1, 16'h0000, 16'h0000, 1, 1, 0));
        vecs.push_back(mk(1, 1, 3, 16'h3333, 1, 3, 3, 3, 1, 16'h3333, 16'h3333, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 3, 3, 0, 1, 16'h3333, 16'h0000, 0, 1, 0));
        vecs.push_back(mk(1, 1, 3, 16'h4444, 0, 3, 3, 3, 1, 16'h4444, 16'h4444, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 3, 1, 16'h0000, 16'h4444, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 3, 1, 16'h0000, 16'h4444, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 3, 1, 16'h0000, 16'h4444, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 3, 1, 16'h0000, 16'h4444, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 3, 1, 16'h0000, 16'h4444, 0, 1, 1));
        vecs.push_back(mk(1, 1, 0, 16'h0AAA, 0, 0, 0, 3, 1, 16'h0AAA, 16'h4444, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 3, 1, 16'h0AAA, 16'h4444, 0, 1, 0));
        vecs.push_back(mk(1, 1, 2, 16'h5555, 0, 2, 2, 0, 1, 16'h5555, 16'h0AAA, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 2, 2, 2, 1, 16'h5555, 16'h5555, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 2, 1, 16'h0022, 16'h5555, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 2, 1, 16'h0022, 16'h5555, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 16'hBEEF, 1, 1, 1, 1, 0, 16'h0000, 16'h0000, 1, 1, 0));

        next_cycle();

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].ie, vecs[i].ia, vecs[i].ra1, vecs[i].ra2);
            #2;
            if (vecs[i].chk) begin
                check($sformatf("v%0d rd_data1", i), 32'(rd_data1), 32'(vecs[i].ed1));
                check($sformatf("v%0d rd_data2", i), 32'(rd_data2), 32'(vecs[i].ed2));
                check($sformatf("v%0d rd_ready1", i), 32'(rd_ready1), 32'(vecs[i].er1));
                check($sformatf("v%0d rd_ready2", i), 32'(rd_ready2), 32'(vecs[i].er2));
                check($sformatf("v%0d issue_full", i), 32'(issue_full), 32'(vecs[i].ef));
            end
            next_cycle();
        end

        // After the mid-operation reset: the BEEF write and the issue are
        // discarded and every register is clean.
        for (int a = 0; a < 4; a++) begin
            drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, rf_addr_t'(a), rf_addr_t'(a), rf_addr_t'(a));
            #2;
            check($sformatf("post_rst r%0d rd_data1", a), 32'(rd_data1), 32'h0);
            check($sformatf("post_rst r%0d rd_data2", a), 32'(rd_data2), 32'h0);
            check($sformatf("post_rst r%0d rd_ready1", a), 32'(rd_ready1), 32'h1);
            check($sformatf("post_rst r%0d rd_ready2", a), 32'(rd_ready2), 32'h1);
            check($sformatf("post_rst r%0d issue_full", a), 32'(issue_full), 32'h0);
            next_cycle();
        end

        // Zero-register variant: writes and issues to reg 0 are ignored.
        drive(1'b1, 1'b1, 2'd0, 16'hFFFF, 1'b1, 2'd0, 2'd0, 2'd0);
        #2;
        check("zr fwd rd_data1", 32'(z_rd_data1), 32'h0);
        check("zr fwd rd_ready1", 32'(z_rd_ready1), 32'h1);
        check("zr fwd issue_full", 32'(z_issue_full), 32'h0);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 2'd0, 2'd1);
            #2;
            check($sformatf("zr issue%0d issue_full", k), 32'(z_issue_full), 32'h0);
            check($sformatf("zr issue%0d rd_ready1", k), 32'(z_rd_ready1), 32'h1);
            next_cycle();
        end
        drive(1'b1, 1'b1, 2'd1, 16'h1234, 1'b0, 2'd0, 2'd0, 2'd1);
        #2;
        check("zr idle rd_data1", 32'(z_rd_data1), 32'h0);
        check("zr idle rd_ready1", 32'(z_rd_ready1), 32'h1);
        check("zr idle issue_full", 32'(z_issue_full), 32'h0);
        check("zr r1 fwd rd_data2", 32'(z_rd_data2), 32'h1234);
        next_cycle();
        drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd1, 2'd0);
        #2;
        check("zr r1 stored rd_data1", 32'(z_rd_data1), 32'h1234);
        check("zr r0 stored rd_data2", 32'(z_rd_data2), 32'h0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
